prog_interval_timer: RTL and testbench

Parametrised interval timer, successor to the fixed one-second timer. A prescaler divides the clock into base ticks of PRESCALE cycles. A loadable down-counter counts N base ticks, then emits a single-cycle timeout pulse. The block supports start/restart, abort, enable-gated freezing, an observable remaining count, and an optional periodic auto-reload mode. It sits between the 50 MHz clock domain logic and game/sequence FSMs that need programmable delays.

---
 rtl/prog_interval_timer.sv | 156 +++++++++++++++
 tb/tb_prog_interval_timer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_interval_timer.sv
// ---------------------------------------------------------------------------
// prog_interval_timer
//
// Programmable interval timer. A prescaler divides clk into base ticks of
// PRESCALE cycles. A loadable down-counter counts N base ticks and then
// emits a single-cycle timeout pulse. The timer can be started, restarted
// and aborted, and enable freezes it. With PIT_PERIODIC_EN defined, a run
// started with periodic=1 auto-reloads and keeps producing timeouts.
//
// Optional feature macro: PIT_PERIODIC_EN (enables periodic auto-reload).
//
// Parameters:
//   PRESCALE   clock cycles per base tick (>= 1)
//   CNT_W      width of the tick count
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   enable     advance prescaler/counter when high, freeze when low
//   start      single-cycle start/restart request, latches load_val
//   stop       single-cycle abort, highest priority
//   periodic   auto-reload select, sampled at start
//   load_val   base ticks per period (N)
//   timeout    one-cycle pulse at the end of each period (registered)
//   busy       high while running (registered)
//   remaining  base ticks left in the current period (registered)
// ---------------------------------------------------------------------------
module prog_interval_timer #(
    parameter int unsigned PRESCALE = 5_000_000,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [CNT_W-1:0] load_val,
    output logic             timeout,
    output logic             busy,
    output logic [CNT_W-1:0] remaining
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             timeout_q, timeout_d;

    // A valid (re)start: stop wins, and a zero count never loads.
    logic load_c;
    logic reload_c;

    assign load_c = !stop && start && (load_val != '0);

`ifdef PIT_PERIODIC_EN
    logic mode_q, mode_d;

    // Mode is captured only on a valid (re)start.
    always_comb begin
        mode_d = mode_q;
        if (load_c) begin
            mode_d = periodic;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign reload_c = mode_q;
`else
    logic unused_periodic;

    // Every run is one-shot; the periodic input has no effect.
    assign unused_periodic = periodic;
    assign reload_c        = 1'b0;
`endif

    // Next-state and counter logic.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        period_d    = period_q;
        remaining_d = remaining_q;
        timeout_d   = 1'b0;

        if (stop) begin
            state_d     = IDLE;
            presc_d     = '0;
            remaining_d = '0;
        end else if (start) begin
            if (load_c) begin
                state_d     = RUN;
                presc_d     = '0;
                period_d    = load_val;
                remaining_d = load_val;
            end else if (state_q == RUN) begin
                // Restart with a zero count behaves as an abort.
                state_d     = IDLE;
                presc_d     = '0;
                remaining_d = '0;
            end
        end else if ((state_q == RUN) && enable) begin
            if (presc_q == PRE_MAX) begin
                presc_d = '0;
                if (remaining_q == CNT_W'(1)) begin
                    timeout_d = 1'b1;
                    if (reload_c) begin
                        remaining_d = period_q;
                    end else begin
                        remaining_d = '0;
                        state_d     = IDLE;
                    end
                end else begin
                    remaining_d = remaining_q - CNT_W'(1);
                end
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            period_q    <= '0;
            remaining_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            period_q    <= period_d;
            remaining_q <= remaining_d;
            timeout_q   <= timeout_d;
        end
    end

    assign timeout   = timeout_q;
    assign busy      = (state_q == RUN);
    assign remaining = remaining_q;

endmodule

// File: tb/tb_prog_interval_timer.sv
// ---------------------------------------------------------------------------
// tb_prog_interval_timer
//
// Self-checking bench for prog_interval_timer with PRESCALE=4, CNT_W=4.
// The driver applies directed and random stimulus, advances an arithmetic
// reference model (elapsed enabled cycles since start) and queues the
// expected outputs for each edge; a negedge monitor pops and compares.
// Honours PIT_PERIODIC_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_prog_interval_timer;

    localparam int unsigned P = 4;
    localparam int unsigned W = 4;

    typedef struct {
        logic         busy;
        logic         timeout;
        logic [W-1:0] rem;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         start;
    logic         stop;
    logic         periodic;
    logic [W-1:0] load_val;
    logic         timeout;
    logic         busy;
    logic [W-1:0] remaining;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;
    int   cyc;

    // Reference model: a run is described by its length N, its mode and
    // the number of enabled cycles elapsed since it was (re)started.
    int   m_active;
    int   m_n;
    int   m_per;
    int   m_elapsed;

    prog_interval_timer #(
        .PRESCALE(P),
        .CNT_W   (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .load_val (load_val),
        .timeout  (timeout),
        .busy     (busy),
        .remaining(remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compute the outputs expected after the coming rising edge.
    task automatic model_edge(output exp_t e);
        e.timeout = 1'b0;
        if (!rst) begin
            m_active = 0;
        end else if (stop) begin
            m_active = 0;
        end else if (start) begin
            if (load_val != 0) begin
                m_active  = 1;
                m_n       = int'(load_val);
                m_elapsed = 0;
`ifdef PIT_PERIODIC_EN
                m_per     = int'(periodic);
`else
                m_per     = 0;
`endif
            end else begin
                m_active = 0;
            end
        end else if (m_active != 0 && enable) begin
            m_elapsed++;
            if (m_elapsed % (m_n * P) == 0) begin
                e.timeout = 1'b1;
                if (m_per == 0) m_active = 0;
            end
        end
        e.busy = (m_active != 0);
        e.rem  = (m_active != 0) ? W'(m_n - (m_elapsed % (m_n * P)) / P) : W'(0);
    endtask

    // Apply one cycle of stimulus; called just after a falling edge.
    task automatic step(input logic st, input logic sp, input logic en,
                        input logic per, input logic [W-1:0] lv);
        exp_t e;
        start    = st;
        stop     = sp;
        enable   = en;
        periodic = per;
        load_val = lv;
        model_edge(e);
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, W'(0));
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if (busy !== 1'b0 || timeout !== 1'b0 || remaining !== W'(0)) begin
            n_fail++;
            $display("FAIL %s: busy=%b timeout=%b remaining=%0d, required all zero",
                     name, busy, timeout, remaining);
        end
    endtask

    // Monitor: every edge has queued expectations; compare after it.
    always @(negedge clk) begin
        cyc++;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (busy !== e.busy || timeout !== e.timeout || remaining !== e.rem) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: busy=%b timeout=%b remaining=%0d, required busy=%b timeout=%b remaining=%0d",
                         cyc, busy, timeout, remaining, e.busy, e.timeout, e.rem);
            end
        end
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        m_active  = 0;
        m_n       = 1;
        m_per     = 0;
        m_elapsed = 0;
        rst       = 1'b0;
        enable    = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        periodic  = 1'b0;
        load_val  = '0;

        // Reset hold, then release with no stimulus.
        #2;
        check_zero("reset_state");
        @(negedge clk);
        #1;
        step(1'b0, 1'b0, 1'b1, 1'b0, W'(0));
        step(1'b1, 1'b0, 1'b1, 1'b0, W'(3));   // start while in reset is ignored
        rst = 1'b1;
        idle(50);

        // One-shot, N=3.
        step(1'b1, 1'b0, 1'b1, 1'b0, W'(3));
        idle(16);

        // Periodic, N=2, stop at edge 26.
        step(1'b1, 1'b0, 1'b1, 1'b1, W'(2));
        idle(25);
        step(1'b0, 1'b1, 1'b1, 1'b0, W'(0));
        idle(12);

        // N=3 with enable low for edges 5..9.
        step(1'b1, 1'b0, 1'b1, 1'b0, W'(3));
        idle(4);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, W'(0));
        idle(14);

        // Start with load_val=0 is ignored.
        step(1'b1, 1'b0, 1'b1, 1'b1, W'(0));
        idle(5);

        // Restart at edge 10 of an N=3 run.
        step(1'b1, 1'b0, 1'b1, 1'b0, W'(3));
        idle(9);
        step(1'b1, 1'b0, 1'b1, 1'b0, W'(3));
        idle(15);

        // Restart with load_val=0 while running aborts.
        step(1'b1, 1'b0, 1'b1, 1'b0, W'(5));
        idle(6);
        step(1'b1, 1'b0, 1'b1, 1'b0, W'(0));
        idle(4);

        // Stop and start together.
        step(1'b1, 1'b0, 1'b1, 1'b0, W'(3));
        idle(3);
        step(1'b1, 1'b1, 1'b1, 1'b0, W'(4));
        idle(6);

        // Stop coincident with the final tick (edge 8 of N=2).
        step(1'b1, 1'b0, 1'b1, 1'b0, W'(2));
        idle(7);
        step(1'b0, 1'b1, 1'b1, 1'b0, W'(0));
        idle(6);

        // Restart coincident with a tick produces no timeout.
        step(1'b1, 1'b0, 1'b1, 1'b0, W'(1));
        idle(3);
        step(1'b1, 1'b0, 1'b1, 1'b0, W'(2));
        idle(10);

        // Asynchronous reset in cycle 6 of an N=2 run.
        step(1'b1, 1'b0, 1'b1, 1'b0, W'(2));
        idle(5);
        rst = 1'b0;
        #1;
        check_zero("async_reset");
        m_active = 0;
        idle(3);
        rst = 1'b1;
        idle(20);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 1)),
                 W'($urandom_range(0, 15)));
        end
        idle(80);

        // Every queued expectation must have been checked.
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
